truth_table_sweeper: RTL

Sequential exerciser for the three-input logic-function exercises (A, B, C -> Y). It drives every input combination onto the shared A/B/C inputs of up to three parallel implementations: sum-of-products, product-of-sums and Karnaugh-reduced. It samples their Y outputs, builds one 8-bit truth table per implementation and flags mismatches against a golden table. It sits on the stimulus/response side of the combinational blocks, as their board-level or bench-level checker.

---
 rtl/truth_table_sweeper.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight {A,B,C} vectors across three parallel logic implementations,
// captures one truth table per implementation and flags mismatches against a golden table.

module truth_table_sweeper_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sampleEn,
  input  logic [2:0] idx,
  input  logic       y,
  input  logic       expBit,
  output logic [7:0] tt,
  output logic       miss
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt   <= '0;
      miss <= 1'b0;
    end else if (clear) begin
      tt   <= '0;
      miss <= 1'b0;
    end else if (sampleEn) begin
      tt[idx] <= y;
      miss    <= miss | (y ^ expBit);
    end
  end
endmodule

module truth_table_sweeper #(
  parameter int          SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = 8'h8A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] abc,
  input  logic [2:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt0,
  output logic [7:0] tt1,
  output logic [7:0] tt2,
  output logic [2:0] mismatch,
  output logic       fail_valid,
  output logic [2:0] first_fail_idx,
  output logic       pass
);
  localparam int         NUM_LANES = 3;
  localparam logic [3:0] RELOAD    = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} stateT;

  stateT      state, nextState;
  logic [2:0] idx, nextIdx;
  logic [3:0] cnt, nextCnt;
  logic       accept, sampleEn, anyDiff, nextActive;
  logic [NUM_LANES-1:0][7:0] ttArr;

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    nextCnt   = cnt;
    accept    = 1'b0;
    sampleEn  = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          nextState = DRIVE;
          nextIdx   = 3'd0;
          nextCnt   = RELOAD;
          accept    = 1'b1;
        end
      DRIVE:
        if (cnt == 4'd0) nextState = SAMPLE;
        else             nextCnt   = cnt - 4'd1;
      SAMPLE: begin
        sampleEn = 1'b1;
        if (idx == 3'd7) nextState = DONE;
        else begin
          nextState = DRIVE;
          nextIdx   = idx + 3'd1;
          nextCnt   = RELOAD;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // abc/busy/done are registered from next-state so they line up with the state they describe
  assign nextActive = (nextState == DRIVE) || (nextState == SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      abc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
      cnt   <= nextCnt;
      abc   <= nextActive ? nextIdx : 3'd0;
      busy  <= nextActive;
      done  <= (nextState == DONE);
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : gLane
      truth_table_sweeper_lane uLane (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .sampleEn (sampleEn),
        .idx      (idx),
        .y        (y_in[i]),
        .expBit   (EXPECTED[idx]),
        .tt       (ttArr[i]),
        .miss     (mismatch[i])
      );
    end
  endgenerate

  assign anyDiff = |(y_in ^ {NUM_LANES{EXPECTED[idx]}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (accept) begin
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else if (sampleEn && anyDiff && !fail_valid) begin
      fail_valid     <= 1'b1;
      first_fail_idx <= idx;
    end
  end

  assign tt0  = ttArr[0];
  assign tt1  = ttArr[1];
  assign tt2  = ttArr[2];
  assign pass = ~busy & ~fail_valid;
endmodule
